// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract sequencer for an external 1-bit full adder stage.
//   On an accepted start it loads the operands and then feeds the adder one
//   bit pair per cycle, LSB first, together with the registered carry. It
//   collects the sum bits back into a shift register. After NrOfBits cycles
//   it presents the result and the flags, with a one-cycle done pulse.
//
//   Optional feature macro: SERIAL_ADDER_ZERO_FLAG_EN
//     defined   : zero_o is registered as (result == 0) at DONE entry
//     undefined : zero_o is tied low and no compare logic is built
//
// Ports
//   clock_i         system clock, rising edge
//   reset_i         synchronous, active-high reset
//   start_i         operation request, sampled only in IDLE or DONE
//   subtract_i      0: A+B, 1: A-B (sampled with start_i)
//   data_a_i        operand A (sampled with start_i)
//   data_b_i        operand B (sampled with start_i)
//   fa_data_a_o     to adder A input     (A shift register bit 0)
//   fa_data_b_o     to adder B input     (B shift register bit 0)
//   fa_carry_in_o   to adder carry input (carry register)
//   fa_result_i     sum bit from adder
//   fa_carry_out_i  carry out from adder
//   busy_o          high while shifting
//   done_o          one-cycle pulse, result valid
//   result_o        sum/difference, held until the next completed operation
//   carry_out_o     final carry; for subtract, 1 = no borrow
//   overflow_o      two's-complement overflow
//   zero_o          result == 0 (see macro above)
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | one operand bit pair per cycle through the adder
// DONE   | result valid for one cycle; start here chains the next operation

module serial_adder_ctrl #(
   parameter int NrOfBits = 8
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                start_i,
   input  logic                subtract_i,
   input  logic [NrOfBits-1:0] data_a_i,
   input  logic [NrOfBits-1:0] data_b_i,
   output logic                fa_data_a_o,
   output logic                fa_data_b_o,
   output logic                fa_carry_in_o,
   input  logic                fa_result_i,
   input  logic                fa_carry_out_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [NrOfBits-1:0] result_o,
   output logic                carry_out_o,
   output logic                overflow_o,
   output logic                zero_o
);

   localparam int CntW = $clog2(NrOfBits);
   localparam logic [CntW-1:0] LastCnt = CntW'(NrOfBits - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [NrOfBits-1:0] a_sh_q, a_sh_d;
   logic [NrOfBits-1:0] b_sh_q, b_sh_d;
   logic [NrOfBits-1:0] r_sh_q, r_sh_d;
   logic                carry_q, carry_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [NrOfBits-1:0] result_q, result_d;
   logic                carry_out_q, carry_out_d;
   logic                overflow_q, overflow_d;
   logic [NrOfBits-1:0] r_next;
   logic                load;

   // Sum register as it will look after this cycle's adder bit is shifted in;
   // on the last shift this is the final result.
   assign r_next = {fa_result_i, r_sh_q[NrOfBits-1:1]};

   assign load = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      r_sh_d      = r_sh_q;
      carry_d     = carry_q;
      count_d     = count_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      case (state_q)
         ST_SHIFT: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = r_next;
            carry_d = fa_carry_out_i;
            count_d = count_q + CntW'(1);
            if (count_q == LastCnt) begin
               state_d     = ST_DONE;
               result_d    = r_next;
               carry_out_d = fa_carry_out_i;
               // carry_q is the carry into the MSB during the last shift
               overflow_d  = carry_q ^ fa_carry_out_i;
            end
         end
         ST_IDLE, ST_DONE: begin
            if (load) begin
               state_d = ST_SHIFT;
               a_sh_d  = data_a_i;
               // subtraction as A + ~B + 1: invert B, preset the carry
               b_sh_d  = subtract_i ? ~data_b_i : data_b_i;
               carry_d = subtract_i;
               count_d = '0;
               r_sh_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         r_sh_q      <= '0;
         carry_q     <= 1'b0;
         count_q     <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         r_sh_q      <= r_sh_d;
         carry_q     <= carry_d;
         count_q     <= count_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef SERIAL_ADDER_ZERO_FLAG_EN
   logic zero_q, zero_d;

   always_comb begin
      zero_d = zero_q;
      if ((state_q == ST_SHIFT) && (count_q == LastCnt)) begin
         zero_d = (r_next == '0);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign zero_o = zero_q;
`else
   assign zero_o = 1'b0;
`endif

   assign fa_data_a_o   = a_sh_q[0];
   assign fa_data_b_o   = b_sh_q[0];
   assign fa_carry_in_o = carry_q;

   assign busy_o      = (state_q == ST_SHIFT);
   assign done_o      = (state_q == ST_DONE);
   assign result_o    = result_q;
   assign carry_out_o = carry_out_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [N-1:0] da, db;
   logic         fa_a, fa_b, fa_cin, fa_res, fa_cout;
   logic         busy, done, cout, ovf, zero;
   logic [N-1:0] res;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [N-1:0] res;
      logic         c;
      logic         v;
      logic         z;
      int           cyc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 1-bit full adder stage on the Fa* ports
   assign fa_res  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_adder_ctrl #(.NrOfBits(N)) dut (
      .clock_i       (clk),
      .reset_i       (rst),
      .start_i       (start),
      .subtract_i    (sub),
      .data_a_i      (da),
      .data_b_i      (db),
      .fa_data_a_o   (fa_a),
      .fa_data_b_o   (fa_b),
      .fa_carry_in_o (fa_cin),
      .fa_result_i   (fa_res),
      .fa_carry_out_i(fa_cout),
      .busy_o        (busy),
      .done_o        (done),
      .result_o      (res),
      .carry_out_o   (cout),
      .overflow_o    (ovf),
      .zero_o        (zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge: drives an accepted start for one cycle and queues
   // the hand-computed expected response.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           input logic [N-1:0] er, input logic ec, input logic ev);
      exp_t e;
      start = 1'b1;
      sub   = s;
      da    = a;
      db    = b;
      e.res = er;
      e.c   = ec;
      e.v   = ev;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
      e.z   = (er == '0);
`else
      e.z   = 1'b0;
`endif
      e.cyc = cyc + N + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, %0d results still pending", name, q.size());
         q.delete();
      end
   endtask

   // Monitor: compare every done pulse against the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done high with no pending operation (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("result", res, e.res);
            chk("carry_out", cout, e.c);
            chk("overflow", ovf, e.v);
            chk("zero", zero, e.z);
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      da    = '0;
      db    = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", res, 0);
      chk("rst_carry", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_zero", zero, 1'b0);
      chk("rst_fa_cin", fa_cin, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // 1: 0x35 + 0x4A, busy cycles 1-8, done cycle 9
      start_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("busy_c%0d", k), busy, (k <= 8) ? 1'b1 : 1'b0);
      end
      wait_drain("t1");

      // 2: wrap to zero
      start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_drain("t2");

      // 3: signed overflow on add and on subtract
      start_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      wait_drain("t3a");
      start_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      wait_drain("t3b");

      // 4: subtract with borrow
      start_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      wait_drain("t4");

      // 5: start during SHIFT ignored, then chained start in the DONE cycle
      begin
         int c0;
         c0 = cyc;
         start_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
         while (cyc < c0 + 4) @(negedge clk);
         start = 1'b1;
         da    = 8'hFF;
         db    = 8'hFF;
         @(negedge clk);
         start = 1'b0;
         while (cyc < c0 + 9) @(negedge clk);
         chk("t5_done_cycle_seen", done, 1'b1);
         start_op(8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0);
         wait_drain("t5");
      end

      // 6: reset mid-operation aborts without a done pulse
      begin
         int c0;
         c0 = cyc;
         start_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
         while (cyc < c0 + 5) @(negedge clk);
         rst = 1'b1;
         q.delete();
         @(negedge clk);
         chk("t6_busy", busy, 1'b0);
         chk("t6_done", done, 1'b0);
         chk("t6_result", res, 0);
         chk("t6_carry", cout, 1'b0);
         chk("t6_ovf", ovf, 1'b0);
         chk("t6_zero", zero, 1'b0);
         rst = 1'b0;
         begin
            logic seen;
            seen = 1'b0;
            repeat (12) begin
               @(negedge clk);
               if (done) seen = 1'b1;
            end
            chk("t6_no_done", seen, 1'b0);
         end
         start_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
         wait_drain("t6");
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
